// File: rtl/mem_loader.sv
// Writer side of the convolution data memory: packs a valid/ready byte stream
// little-endian into BPW-byte words and writes num_words words from base_addr.
`timescale 1ns/1ps
module mem_loader #(
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8,
  parameter int BPW    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       num_words,
  input  logic [BYTE_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [BPW*BYTE_W-1:0]   mem_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDR_W-1:0]       base_r;
  logic [ADDR_W-1:0]       num_r;
  logic [ADDR_W-1:0]       word_cnt_r;
  logic [LANE_W-1:0]       lane_cnt_r;
  logic [BPW*BYTE_W-1:0]   shadow_r;
  logic                    trunc_r;

  logic                    in_ready_r;
  logic                    mem_we_r;
  logic [ADDR_W-1:0]       mem_addr_r;
  logic [BPW*BYTE_W-1:0]   mem_wdata_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    err_r;

  logic                    accept_s;
  logic                    lane_last_s;
  logic                    final_word_s;
  logic                    word_end_s;
  logic                    frame_err_s;
  logic [ADDR_W-1:0]       wr_addr_s;
  logic [BPW*BYTE_W-1:0]   packed_s;

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

  // Byte acceptance, lane insertion and framing decisions for the current cycle
  always_comb begin
    accept_s     = in_valid & in_ready_r;
    lane_last_s  = (lane_cnt_r == LAST_LANE);
    final_word_s = ((word_cnt_r + ADDR_W'(1)) == num_r);
    wr_addr_s    = base_r + word_cnt_r;
    // Any in_last closes the frame; a full lane also closes the word
    word_end_s   = lane_last_s | in_last;
    // in_last is legal only on the final lane of the final word, and required there
    frame_err_s  = in_last ^ (lane_last_s & final_word_s);
    packed_s     = shadow_r;
    for (int i = 0; i < BPW; i++) begin
      if (LANE_W'(i) == lane_cnt_r) begin
        packed_s[i*BYTE_W +: BYTE_W] = in_data;
      end else begin
        packed_s[i*BYTE_W +: BYTE_W] = shadow_r[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Load sequencer with registered handshake, memory and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      base_r      <= '0;
      num_r       <= '0;
      word_cnt_r  <= '0;
      lane_cnt_r  <= '0;
      shadow_r    <= '0;
      trunc_r     <= 1'b0;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_we_r <= 1'b0;
          done_r   <= 1'b0;
          if (start) begin
            base_r     <= base_addr;
            num_r      <= num_words;
            word_cnt_r <= '0;
            lane_cnt_r <= '0;
            shadow_r   <= '0;
            trunc_r    <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b1;
            if (num_words == '0) begin
              state_r    <= FINISH;
              done_r     <= 1'b1;
              in_ready_r <= 1'b0;
            end else begin
              state_r    <= COLLECT;
              in_ready_r <= 1'b1;
            end
          end else begin
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end
        end

        COLLECT: begin
          if (accept_s) begin
            if (frame_err_s) begin
              err_r <= 1'b1;
            end else begin
              err_r <= err_r;
            end
            if (word_end_s) begin
              // Unfilled lanes of a truncated word stay zero from the cleared shadow
              state_r     <= WRITE;
              in_ready_r  <= 1'b0;
              mem_we_r    <= 1'b1;
              mem_addr_r  <= wr_addr_s;
              mem_wdata_r <= packed_s;
              trunc_r     <= in_last;
            end else begin
              shadow_r   <= packed_s;
              lane_cnt_r <= lane_cnt_r + LANE_W'(1);
            end
          end else begin
            state_r <= COLLECT;
          end
        end

        WRITE: begin
          mem_we_r    <= 1'b0;
          mem_addr_r  <= '0;
          mem_wdata_r <= '0;
          word_cnt_r  <= word_cnt_r + ADDR_W'(1);
          lane_cnt_r  <= '0;
          shadow_r    <= '0;
          if (final_word_s || trunc_r) begin
            state_r <= FINISH;
            done_r  <= 1'b1;
          end else begin
            state_r    <= COLLECT;
            in_ready_r <= 1'b1;
          end
        end

        FINISH: begin
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b0;
          state_r    <= IDLE;
        end

        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_addr_r  <= '0;
          mem_wdata_r <= '0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: a frame-level reference model queues the
// expected writes and error flag per load; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  num_words;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  mem_loader #(.ADDR_W(8), .BYTE_W(8), .BPW(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .base_addr(base_addr), .num_words(num_words),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int          n_checks   = 0;
  int          n_pass     = 0;
  int          done_count = 0;
  logic        done_prev  = 1'b0;
  logic [7:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        exp_err_q[$];
  logic [7:0]  frame[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Frame-level model: a load consumes bytes up to the first in_last or 4*n bytes
  task automatic push_expect(input logic [7:0] base, input int n, input int lastp);
    int consumed;
    int words;
    logic [31:0] w;
    if (n == 0) begin
      exp_err_q.push_back(1'b0);
      return;
    end
    consumed = (lastp >= 0 && lastp < 4*n) ? lastp + 1 : 4*n;
    words = (consumed + 3) / 4;
    for (int wi = 0; wi < words; wi++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4*wi + b < consumed) w[8*b +: 8] = frame[4*wi + b];
      exp_addr_q.push_back(8'(int'(base) + wi));
      exp_data_q.push_back(w);
    end
    exp_err_q.push_back(lastp != 4*n - 1);
  endtask

  task automatic make_random_frame(input int len);
    frame.delete();
    for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // mode: 0 always valid, 1 valid every other cycle, 2 random gaps
  task automatic run_load(input logic [7:0] base, input int n, input int lastp,
                          input int mode, input int glitch_idx, input int stop_after);
    int idx;
    int cyc;
    int t;
    int d0;
    logic v;
    logic acc;
    if (stop_after < 0) push_expect(base, n, lastp);
    d0 = done_count;
    @(negedge clock);
    start = 1'b1; base_addr = base; num_words = 8'(n);
    @(negedge clock);
    start = 1'b0; base_addr = 8'($urandom); num_words = 8'($urandom);
    idx = 0; cyc = 0;
    while (idx < frame.size() && done_count == d0 && cyc < 1000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v; in_data = frame[idx]; in_last = (idx == lastp);
      start = (idx == glitch_idx);
      if (start) base_addr = 8'h55;
      acc = v && in_ready;
      @(posedge clock);
      if (acc) idx++;
      @(negedge clock);
      cyc++;
      if (stop_after >= 0 && idx >= stop_after) break;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    if (stop_after < 0) begin
      t = 0;
      while (done_count == d0 && t < 200) begin
        @(negedge clock);
        t++;
      end
      chk("load_done_seen", 32'(done_count != d0), 32'd1);
      if (n == 0) chk("empty_load_latency", 32'(t <= 2), 32'd1);
      @(negedge clock);
      chk("busy_low_after_done", 32'(busy), 32'd0);
    end
  endtask

  // Monitor: compares every write and every done pulse against the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        done_prev = 1'b0;
      end else begin
        if (mem_we) begin
          chk("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
          if (exp_addr_q.size() != 0) begin
            chk("write_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            chk("write_data", mem_wdata, exp_data_q.pop_front());
          end
          chk("ready_low_in_write", 32'(in_ready), 32'd0);
        end
        if (done) begin
          done_count++;
          chk("done_single_cycle", 32'(done_prev), 32'd0);
          chk("writes_complete_at_done", 32'(exp_addr_q.size()), 32'd0);
          chk("done_expected", 32'(exp_err_q.size() != 0), 32'd1);
          if (exp_err_q.size() != 0) chk("err_at_done", 32'(err), 32'(exp_err_q.pop_front()));
        end
        done_prev = done;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int kind;
    int lp;
    reset = 1'b1; start = 1'b0; base_addr = 8'd0; num_words = 8'd0;
    in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Basic two-word load
    frame.delete();
    for (int i = 1; i <= 8; i++) frame.push_back(8'(i));
    run_load(8'h10, 2, 7, 0, -1, -1);

    // Stalled stream, one word
    make_random_frame(4);
    run_load(8'h40, 1, 3, 1, -1, -1);

    // Truncated frame: AA BB CC with last on CC, n=2
    frame.delete();
    frame.push_back(8'hAA); frame.push_back(8'hBB); frame.push_back(8'hCC);
    frame.push_back(8'hDD); frame.push_back(8'hEE);
    run_load(8'h20, 2, 2, 0, -1, -1);

    // Address wrap and empty load
    make_random_frame(12);
    run_load(8'hFE, 3, 11, 2, -1, -1);
    frame.delete();
    run_load(8'h33, 0, -1, 0, -1, -1);

    // Reset after two bytes of word 0
    make_random_frame(8);
    run_load(8'h20, 2, 7, 0, -1, 2);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_idle_outputs("midload_reset");
    reset = 1'b0;
    make_random_frame(8);
    run_load(8'h60, 2, 7, 2, -1, -1);

    // start glitch mid-load, final byte without in_last
    make_random_frame(10);
    run_load(8'h30, 2, -1, 0, 2, -1);

    // Randomized loads
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 5);
      kind = $urandom_range(0, 2);
      case (kind)
        0: lp = 4*n - 1;
        1: lp = $urandom_range(0, 4*n - 2);
        default: lp = -1;
      endcase
      make_random_frame(4*n + 2);
      run_load(8'($urandom), n, lp, $urandom_range(0, 2), -1, -1);
    end

    repeat (3) @(negedge clock);
    chk("no_pending_writes", 32'(exp_addr_q.size()), 32'd0);
    chk("no_pending_done", 32'(exp_err_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
